// File: rtl/quad_encoder_gen.sv
// Quadrature A/B generator: emits a Gray-coded edge sequence for a commanded step count,
// direction and per-step dwell, tracking a signed running position.
module quad_encoder_gen #(
  parameter int unsigned CNT_W = 16,
  parameter int unsigned DIV_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [CNT_W-1:0] cmd_steps,
  input  logic             cmd_dir,
  input  logic [DIV_W-1:0] cmd_dwell,
  input  logic             abort,
  output logic             quad_a,
  output logic             quad_b,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] position
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_RUN    = 2'd1,
    S_FINISH = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] rem_q, rem_d;
  logic [CNT_W-1:0] pos_q, pos_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [DIV_W-1:0] dwell_q, dwell_d;
  logic             dir_q, dir_d;
  logic             a_q, a_d;
  logic             b_q, b_d;
  logic             ready_q, ready_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [DIV_W-1:0] dwell_eff_c;

  // A zero dwell is promoted to one so the divider never starts at zero.
  assign dwell_eff_c = (cmd_dwell == '0) ? DIV_W'(1) : cmd_dwell;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      rem_q   <= '0;
      pos_q   <= '0;
      div_q   <= '0;
      dwell_q <= '0;
      dir_q   <= 1'b0;
      a_q     <= 1'b0;
      b_q     <= 1'b0;
      ready_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      pos_q   <= pos_d;
      div_q   <= div_d;
      dwell_q <= dwell_d;
      dir_q   <= dir_d;
      a_q     <= a_d;
      b_q     <= b_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    pos_d   = pos_q;
    div_d   = div_q;
    dwell_d = dwell_q;
    dir_d   = dir_q;
    a_d     = a_q;
    b_d     = b_q;

    unique case (state_q)
      S_IDLE: begin
        if (cmd_valid && ready_q) begin
          rem_d   = cmd_steps;
          dir_d   = cmd_dir;
          dwell_d = dwell_eff_c;
          div_d   = dwell_eff_c;
          state_d = (cmd_steps != '0) ? S_RUN : S_FINISH;
        end
      end
      S_RUN: begin
        if (abort) begin
          state_d = S_FINISH;
        end else if (div_q == DIV_W'(1)) begin
          // CW rotates AB as 00->10->11->01, CCW walks the same ring backwards.
          if (dir_q) begin
            a_d   = b_q;
            b_d   = ~a_q;
            pos_d = pos_q - CNT_W'(1);
          end else begin
            a_d   = ~b_q;
            b_d   = a_q;
            pos_d = pos_q + CNT_W'(1);
          end
          rem_d = rem_q - CNT_W'(1);
          div_d = dwell_q;
          if (rem_q == CNT_W'(1)) begin
            state_d = S_FINISH;
          end
        end else begin
          div_d = div_q - DIV_W'(1);
        end
      end
      S_FINISH: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    ready_d = (state_d == S_IDLE);
    busy_d  = (state_d == S_RUN);
    done_d  = (state_d == S_FINISH);
  end

  assign cmd_ready = ready_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign quad_a    = a_q;
  assign quad_b    = b_q;
  assign position  = pos_q;

endmodule
